flight_term_sm: RTL and testbench
=================================

# flight_term_sm

Parametrised flight-termination sequencer, successor to the single-channel StateMachine.
- Measures a programming pulse on `datapin` to set the flight-time budget.
- Tracks acceleration and flight via `accelpin` and `flightpin`, both active-low with pull-ups.
- When the budget expires, drives `NCH` staggered termination outputs.
- Adds input synchronisation and debounce, a tick prescaler, a saturating counter, a disarm path and an optional accel watchdog.
- Sits between the ESP32 GPIO pins and the pyro/cut-down drivers.

## Interface
- `CNT_W`, 16: width of the time counters `powertime`, `programtime` and `flighttime`.
- `PRESCALE`, 1: clk cycles per timing tick; must be ≥1.
- `DEB_N`, 4: consecutive identical synchronised samples needed to accept a new input level; must be ≥1.
- `NCH`, 2: number of termination channels; must be ≥1.
- `STAGGER`, 8: ticks between successive channel assertions.
- `WD_TICKS`, 1000: accel watchdog limit in ticks; used only with `FLIGHT_TERM_WATCHDOG_EN`.
- `clk` in 1: system clock, nominally 50 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `datapin` in 1: programming pulse; high time sets the budget.
- `accelpin` in 1: active-low; low means accelerating.
- `flightpin` in 1: active-low; low means in flight.
- `terminatepin` out `NCH`: termination outputs; sticky high once asserted.
- `state` out 3: current state, encoded IDLE=0, ACCEL=1, FLIGHT=2, TERMINATE=3.
- `programtime` out `CNT_W`: latched flight budget in ticks.
- `program_valid` out 1: a non-zero budget has been latched.

## Operation
- **Input conditioning:** each pin passes through a 2-FF synchroniser, then a debouncer. The debounced level changes only after `DEB_N` consecutive synchronised samples differ from it. Debounced `accelpin`/`flightpin` reset to 1; debounced `datapin` resets to 0.
- **Tick:** the prescaler counts 0..`PRESCALE`-1 and emits a tick on wrap. With `PRESCALE`=1 the tick is asserted every cycle. The prescaler runs free from reset.
- **Programming, IDLE only:**
  - Rising edge of debounced `datapin`: clear `powertime`.
  - While high, `powertime` increments on each tick and saturates at 2^`CNT_W`-1.
  - Falling edge: if `powertime`≠0, latch `programtime`=`powertime` and set `program_valid`=1. A zero-length pulse is ignored.
  - A later pulse overwrites the budget.
  - `datapin` activity in any other state is ignored.
- **State machine:**
  - IDLE→ACCEL when debounced `accelpin`=0 and `program_valid`=1. With no valid program, stay in IDLE.
  - ACCEL→FLIGHT when debounced `flightpin`=0. This transition clears `flighttime` to 0.
  - ACCEL→IDLE when debounced `accelpin` returns to 1 while `flightpin`=1 (disarm). The program is retained.
  - If `flightpin` and `accelpin` change in the same cycle in ACCEL, FLIGHT wins.
  - FLIGHT: `flighttime` increments on each tick. When `flighttime`==`programtime`, go to TERMINATE. Pin changes in FLIGHT are ignored.
  - TERMINATE is absorbing; only `rst_n` exits it.
- **Channels:**
  - Channel 0 asserts on the same edge that `state` becomes TERMINATE.
  - A stagger counter starts at 0 on TERMINATE entry and increments per tick, saturating at `CNT_W` bits.
  - Channel k asserts when the stagger counter reaches k·`STAGGER`.
  - All channels stay high until reset.
- **Reset:**
  - Asynchronous assertion at any time, including mid-flight, forces `state`=IDLE, `terminatepin`=0, `programtime`=0, `program_valid`=0.
  - All counters, the prescaler and the sync/debounce registers are cleared.

## Timing
- Pin-to-debounced latency is 2+`DEB_N` clk cycles. It is identical for both edges, so the measured pulse width is preserved.
- State transitions are registered: `state` updates 1 cycle after the debounced condition is true.
- Budget: `terminatepin[0]` rises `programtime` ticks after FLIGHT entry, +1 clk for the compare.
- Channel k rises k·`STAGGER` ticks after channel 0.
- The `programtime`/`program_valid` update lands 1 cycle after the debounced falling edge.
- All outputs are registered, with no combinational paths from inputs.

## Configuration
- **`FLIGHT_TERM_WATCHDOG_EN` defined:** a watchdog counter clears on ACCEL entry and counts ticks in ACCEL. When it reaches `WD_TICKS` without a FLIGHT transition, the block goes to TERMINATE with normal channel sequencing. Disarm to IDLE clears the counter.
- **Not defined:** there is no watchdog logic, and ACCEL waits indefinitely.

## Test plan
All scenarios use `CNT_W`=8, `PRESCALE`=1, `DEB_N`=2, `NCH`=2, `STAGGER`=4, `WD_TICKS`=20.
- **Reset:** assert `rst_n`=0 with pins high → `state`=0, `terminatepin`=2'b00, `programtime`=0, `program_valid`=0. Repeat with `rst_n` pulsed low mid-FLIGHT → same values on the next observation.
- **Programming:** `datapin` high 10 cycles then low → `programtime`=10, `program_valid`=1. A second pulse of 6 cycles → `programtime`=6. A pulse held 300 cycles → `programtime`=255 (saturated).
- **Glitch rejection and arming guard:**
  - A 1-cycle `datapin` glitch → `programtime` unchanged.
  - `accelpin` low before any program → `state` stays 0.
- **Full sequence:**
  - With `programtime`=6, drive `accelpin`=0 → `state`=1.
  - Drive `flightpin`=0 → `state`=2.
  - `terminatepin[0]` rises 7 cycles after `state`=2, together with `state`=3.
  - `terminatepin[1]` rises 4 cycles after `terminatepin[0]`.
  - Both stay high when pins are released.
- **Disarm:** `accelpin` low 10 cycles then high with `flightpin` high → `state` returns 0 and `programtime` stays 6. Re-arming works.
- **Watchdog:**
  - With the macro defined, hold `accelpin`=0 and `flightpin`=1 → `state`=3 and `terminatepin[0]`=1 about 20 cycles after `state`=1.
  - With the macro undefined → `state` stays 1 for 1000 cycles.

Source files
------------

// File: rtl/flight_term_sm.sv
// Flight-termination sequencer: pulse-programmed budget, staggered pyro channels.
// Optional accel watchdog enabled by defining FLIGHT_TERM_WATCHDOG_EN.
module flight_term_sm #(
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 1,
    parameter int DEB_N    = 4,
    parameter int NCH      = 2,
    parameter int STAGGER  = 8,
    parameter int WD_TICKS = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             datapin,
    input  logic             accelpin,
    input  logic             flightpin,
    output logic [NCH-1:0]   terminatepin,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] programtime,
    output logic             program_valid
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACCEL     = 3'd1,
        FLIGHT    = 3'd2,
        TERMINATE = 3'd3
    } state_t;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = $clog2(DEB_N + 1);
    localparam int CW = CNT_W + 32;
    localparam logic [CNT_W-1:0] CMAX = '1;
    // Idle pin levels: flight/accel pulled high, data low.
    localparam logic [2:0] PIN_IDLE = 3'b110;

    if (PRESCALE < 1 || DEB_N < 1 || NCH < 1 || WD_TICKS < 1) begin : g_bad_param
        $error("flight_term_sm: PRESCALE, DEB_N, NCH and WD_TICKS must be >= 1");
    end

    state_t cur, nxt;
    logic [2:0] pins, meta, sync, deb;
    logic [DW-1:0] dcnt [3];
    logic [PW-1:0] pre;
    logic tick;
    logic data_q, meas;
    logic [CNT_W-1:0] powertime, flighttime, stagger, stg_nxt;
    logic [NCH-1:0] term_nxt;
    logic enter_term;

    assign state = cur;
    assign pins  = {flightpin, accelpin, datapin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= PIN_IDLE;
            sync <= PIN_IDLE;
            deb  <= PIN_IDLE;
            for (int i = 0; i < 3; i++) dcnt[i] <= '0;
        end else begin
            meta <= pins;
            sync <= meta;
            for (int i = 0; i < 3; i++) begin
                if (sync[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DW'(DEB_N - 1)) begin
                    deb[i]  <= sync[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    assign tick = (pre == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + 1'b1;
    end

`ifdef FLIGHT_TERM_WATCHDOG_EN
    localparam int WW = $clog2(WD_TICKS + 1);
    logic [WW-1:0] wd;
    logic wd_hit;

    assign wd_hit = (wd == WW'(WD_TICKS));

    // Held at zero outside ACCEL, so entry and disarm both restart it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       wd <= '0;
        else if (cur != ACCEL)            wd <= '0;
        else if (tick && !wd_hit)         wd <= wd + 1'b1;
    end
`endif

    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE:   if (!deb[1] && program_valid) nxt = ACCEL;
            ACCEL: begin
                if (!deb[2])     nxt = FLIGHT;
                else if (deb[1]) nxt = IDLE;
`ifdef FLIGHT_TERM_WATCHDOG_EN
                else if (wd_hit) nxt = TERMINATE;
`endif
            end
            FLIGHT: if (flighttime == programtime) nxt = TERMINATE;
            TERMINATE: nxt = TERMINATE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= IDLE;
        else        cur <= nxt;
    end

    // A measurement only counts if its rising edge was seen in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q        <= 1'b0;
            meas          <= 1'b0;
            powertime     <= '0;
            programtime   <= '0;
            program_valid <= 1'b0;
        end else begin
            data_q <= deb[0];
            if (cur != IDLE) begin
                meas <= 1'b0;
            end else if (deb[0] && !data_q) begin
                meas      <= 1'b1;
                powertime <= {{(CNT_W-1){1'b0}}, tick};
            end else if (deb[0] && meas) begin
                if (tick && powertime != CMAX) powertime <= powertime + 1'b1;
            end else if (!deb[0] && data_q && meas) begin
                meas <= 1'b0;
                if (powertime != '0) begin
                    programtime   <= powertime;
                    program_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flighttime <= '0;
        end else if (cur == ACCEL && nxt == FLIGHT) begin
            flighttime <= '0;
        end else if (cur == FLIGHT && tick && flighttime != CMAX) begin
            flighttime <= flighttime + 1'b1;
        end
    end

    assign enter_term = (cur != TERMINATE) && (nxt == TERMINATE);

    always_comb begin
        stg_nxt = stagger;
        if (tick && stagger != CMAX) stg_nxt = stagger + 1'b1;
        term_nxt = terminatepin;
        for (int k = 0; k < NCH; k++) begin
            if (enter_term && k * STAGGER == 0)
                term_nxt[k] = 1'b1;
            else if (cur == TERMINATE && {32'd0, stg_nxt} == CW'(k * STAGGER))
                term_nxt[k] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stagger      <= '0;
            terminatepin <= '0;
        end else begin
            terminatepin <= term_nxt;
            if (enter_term)             stagger <= '0;
            else if (cur == TERMINATE)  stagger <= stg_nxt;
        end
    end

endmodule

// File: tb/tb_flight_term_sm.sv
// Directed scoreboard bench for flight_term_sm (small test-plan parameters).
// Watchdog scenario follows FLIGHT_TERM_WATCHDOG_EN.
module tb_flight_term_sm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       datapin, accelpin, flightpin;
    logic [1:0] terminatepin;
    logic [2:0] state;
    logic [7:0] programtime;
    logic       program_valid;

    flight_term_sm #(
        .CNT_W(8), .PRESCALE(1), .DEB_N(2),
        .NCH(2), .STAGGER(4), .WD_TICKS(20)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .datapin(datapin), .accelpin(accelpin), .flightpin(flightpin),
        .terminatepin(terminatepin), .state(state),
        .programtime(programtime), .program_valid(program_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (state == s) break;
            @(negedge clk);
        end
    endtask

    task automatic chk_reset(input string sfx);
        push_exp({"rst_state_", sfx}, 32'd0);
        push_exp({"rst_term_", sfx}, 32'd0);
        push_exp({"rst_ptime_", sfx}, 32'd0);
        push_exp({"rst_valid_", sfx}, 32'd0);
        check(32'(state));
        check(32'(terminatepin));
        check(32'(programtime));
        check(32'(program_valid));
    endtask

    task automatic pulse(input int n);
        datapin = 1'b1;
        step(n);
        datapin = 1'b0;
        step(8);
    endtask

    int n;

    initial begin
        rst_n = 1'b0;
        datapin = 1'b0;
        accelpin = 1'b1;
        flightpin = 1'b1;
        #1;
        chk_reset("init");
        step(2);
        rst_n = 1'b1;
        step(5);

        push_exp("guard_no_program", 32'd0);
        accelpin = 1'b0;
        step(12);
        check(32'(state));
        accelpin = 1'b1;
        step(6);

        push_exp("prog10_time", 32'd10);
        push_exp("prog10_valid", 32'd1);
        pulse(10);
        check(32'(programtime));
        check(32'(program_valid));

        push_exp("prog300_sat", 32'd255);
        pulse(300);
        check(32'(programtime));

        push_exp("prog6_time", 32'd6);
        pulse(6);
        check(32'(programtime));

        push_exp("glitch_kept", 32'd6);
        pulse(1);
        check(32'(programtime));

        push_exp("arm_state", 32'd1);
        accelpin = 1'b0;
        wait_state(3'd1, 12);
        check(32'(state));

        push_exp("flight_state", 32'd2);
        flightpin = 1'b0;
        wait_state(3'd2, 12);
        check(32'(state));

        push_exp("term0_delay", 32'd7);
        push_exp("term_state", 32'd3);
        push_exp("term1_low", 32'd0);
        n = 0;
        while (!terminatepin[0] && n < 50) begin
            step(1);
            n++;
        end
        check(32'(n));
        check(32'(state));
        check(32'(terminatepin[1]));

        push_exp("term1_delay", 32'd4);
        n = 0;
        while (!terminatepin[1] && n < 50) begin
            step(1);
            n++;
        end
        check(32'(n));

        push_exp("sticky_term", 32'd3);
        push_exp("sticky_state", 32'd3);
        accelpin = 1'b1;
        flightpin = 1'b1;
        step(10);
        check(32'(terminatepin));
        check(32'(state));

        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(5);
        push_exp("mid_prog", 32'd6);
        pulse(6);
        check(32'(programtime));
        push_exp("mid_in_flight", 32'd2);
        accelpin = 1'b0;
        wait_state(3'd1, 12);
        flightpin = 1'b0;
        wait_state(3'd2, 12);
        step(3);
        check(32'(state));
        #2;
        rst_n = 1'b0;
        accelpin = 1'b1;
        flightpin = 1'b1;
        #1;
        chk_reset("midflight");
        @(negedge clk);
        rst_n = 1'b1;
        step(5);

        push_exp("disarm_prog", 32'd6);
        pulse(6);
        check(32'(programtime));
        push_exp("disarm_armed", 32'd1);
        accelpin = 1'b0;
        step(10);
        check(32'(state));
        push_exp("disarm_idle", 32'd0);
        push_exp("disarm_keep_prog", 32'd6);
        accelpin = 1'b1;
        wait_state(3'd0, 12);
        check(32'(state));
        check(32'(programtime));

        push_exp("rearm_state", 32'd1);
        accelpin = 1'b0;
        wait_state(3'd1, 12);
        check(32'(state));

`ifdef FLIGHT_TERM_WATCHDOG_EN
        push_exp("wd_not_yet", 32'd1);
        step(15);
        check(32'(state));
        push_exp("wd_state", 32'd3);
        push_exp("wd_term0", 32'd1);
        wait_state(3'd3, 15);
        check(32'(state));
        check(32'(terminatepin[0]));
`else
        push_exp("no_wd_hold", 32'd1);
        push_exp("no_wd_term", 32'd0);
        step(1000);
        check(32'(state));
        check(32'(terminatepin));
        push_exp("no_wd_disarm", 32'd0);
        accelpin = 1'b1;
        wait_state(3'd0, 12);
        check(32'(state));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
